// File: rtl/param_seq_detector.sv
// Serial sequence detector with a runtime-loadable pattern, overlap mode and a saturating hit counter.
// Define SEQ_DET_MASK_EN to add a per-bit compare mask (mask_in, latched on load).
module param_seq_detector #(
  parameter int                   PATTERN_W   = 4,
  parameter int                   CNT_W       = 8,
  parameter logic [PATTERN_W-1:0] RST_PATTERN = 4'b1011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 overlap_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PATTERN_W-1:0] mask_in,
`endif
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 cnt_clr,
  output logic                 z,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 cnt_sat,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  localparam int              FW       = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0]   FILL_MAX = FW'(PATTERN_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state;
  logic [PATTERN_W-1:0] sr;
  logic [FW-1:0]        fill;
  logic [PATTERN_W-1:0] pattern_q;
  logic                 overlap_q;
  logic [PATTERN_W-1:0] cmp_mask;

`ifdef SEQ_DET_MASK_EN
  logic [PATTERN_W-1:0] mask_q;
  assign cmp_mask = mask_q;
`else
  assign cmp_mask = '1;
`endif

  logic [PATTERN_W-1:0] sr_shift;
  logic [FW-1:0]        fill_inc;
  logic                 hit;
  logic                 accept;
  logic [CNT_W-1:0]     cnt_next;

  // x is consumed on any edge with x_valid=1 while en=1, load=0 and the
  // state is FILL or HUNT; there is no backpressure, unaccepted bits are lost.
  always_comb begin
    sr_shift = {sr[PATTERN_W-2:0], x};
    fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;
    hit      = (fill_inc == FILL_MAX) && ((sr_shift & cmp_mask) == (pattern_q & cmp_mask));
    accept   = en && !load && (state != IDLE) && x_valid;
    cnt_next = match_cnt;
    if (cnt_clr)
      cnt_next = '0;
    else if (accept && hit && (match_cnt != CNT_MAX))
      cnt_next = match_cnt + 1'b1;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= '0;
      fill      <= '0;
      pattern_q <= RST_PATTERN;
      overlap_q <= 1'b1;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= '1;
`endif
      z         <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      match_cnt <= cnt_next;
      cnt_sat   <= (cnt_next == CNT_MAX);
      z         <= accept && hit;
      if (load) begin
        pattern_q <= pattern_in;
        overlap_q <= overlap_in;
`ifdef SEQ_DET_MASK_EN
        mask_q    <= mask_in;
`endif
      end
      if (!en) begin
        state <= IDLE;
        busy  <= 1'b0;
        sr    <= '0;
        fill  <= '0;
      end else if (load) begin
        state <= FILL;
        busy  <= 1'b1;
        sr    <= '0;
        fill  <= '0;
      end else if (state == IDLE) begin
        state <= FILL;
        busy  <= 1'b1;
      end else if (x_valid) begin
        sr <= sr_shift;
        // Non-overlap restarts the fill so the next hit needs a full fresh window.
        if (hit && !overlap_q) begin
          fill  <= '0;
          state <= FILL;
        end else begin
          fill  <= fill_inc;
          state <= (fill_inc == FILL_MAX) ? HUNT : FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: directed steps then random traffic against a bit-history model.
module tb_param_seq_detector;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, load, overlap_in, x, x_valid, cnt_clr;
  logic [W-1:0] pattern_in;
`ifdef SEQ_DET_MASK_EN
  logic [W-1:0] mask_in;
`endif
  logic         z_a, sat_a, busy_a, z_b, sat_b, busy_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b, st_a, st_b;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: accepted bits of the current window, newest last
  bit           m_bits[$];
  logic [W-1:0] m_pat;
  bit           m_ovl, m_run, m_z;
  int           m_cnt_a, m_cnt_b;
  logic [15:0]  exp_q[$];

  always #5 clk = ~clk;

  param_seq_detector #(.PATTERN_W(W), .CNT_W(8), .RST_PATTERN(4'b1011)) dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .pattern_in(pattern_in),
    .overlap_in(overlap_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in(mask_in),
`endif
    .x(x), .x_valid(x_valid), .cnt_clr(cnt_clr),
    .z(z_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .busy(busy_a), .state_dbg(st_a)
  );

  param_seq_detector #(.PATTERN_W(W), .CNT_W(2), .RST_PATTERN(4'b1011)) dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .pattern_in(pattern_in),
    .overlap_in(overlap_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in(mask_in),
`endif
    .x(x), .x_valid(x_valid), .cnt_clr(cnt_clr),
    .z(z_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .busy(busy_b), .state_dbg(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat   = 4'b1011;
    m_ovl   = 1'b1;
    m_run   = 1'b0;
    m_z     = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  // One clock of expected behaviour from the current inputs.
  task automatic model_step();
    int         win;
    logic [1:0] st;
    m_z = 1'b0;
    if (!en) begin
      m_run = 1'b0;
      m_bits.delete();
      if (load) begin
        m_pat = pattern_in;
        m_ovl = overlap_in;
      end
    end else if (load) begin
      m_pat = pattern_in;
      m_ovl = overlap_in;
      m_run = 1'b1;
      m_bits.delete();
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (x_valid) begin
      m_bits.push_back(x);
      if (m_bits.size() > W) void'(m_bits.pop_front());
      win = 0;
      foreach (m_bits[i]) win = win * 2 + int'(m_bits[i]);
      m_z = (m_bits.size() == W) && (win == int'(m_pat));
      if (m_z) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
        if (!m_ovl) m_bits.delete();
      end
    end
    if (cnt_clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end
    st = !m_run ? 2'd0 : ((m_bits.size() == W) ? 2'd2 : 2'd1);
    exp_q.push_back({m_z, m_run, st, (m_cnt_a == 255), 8'(m_cnt_a), (m_cnt_b == 3), 2'(m_cnt_b)});
  endtask

  task automatic check_outputs();
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      chk("z_a", z_a, e[15]);
      chk("z_b", z_b, e[15]);
      chk("busy_a", busy_a, e[14]);
      chk("busy_b", busy_b, e[14]);
      chk("state_a", st_a, e[13:12]);
      chk("state_b", st_b, e[13:12]);
      chk("sat_a", sat_a, e[11]);
      chk("cnt_a", cnt_a, e[10:3]);
      chk("sat_b", sat_b, e[2]);
      chk("cnt_b", cnt_b, e[1:0]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Feed n bits MSB first, each followed by `gap` cycles with x_valid=0.
  task automatic send_bits(input logic [15:0] seq, input int n, input int gap);
    load    = 1'b0;
    cnt_clr = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      x       = seq[i];
      x_valid = 1'b1;
      tick();
      for (int g = 0; g < gap; g++) begin
        x       = 1'($urandom_range(0, 1));
        x_valid = 1'b0;
        tick();
      end
    end
    x_valid = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] pat, input logic ovl, input logic xbit);
    load       = 1'b1;
    pattern_in = pat;
    overlap_in = ovl;
    x          = xbit;
    x_valid    = 1'b1;
    tick();
    load    = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_z"}, z_a, 1'b0);
    chk({tag, "_cnt_a"}, cnt_a, 8'd0);
    chk({tag, "_cnt_b"}, cnt_b, 2'd0);
    chk({tag, "_busy"}, busy_a, 1'b0);
    chk({tag, "_sat"}, sat_b, 1'b0);
    chk({tag, "_state"}, st_a, 2'd0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; overlap_in = 1'b0; x = 1'b0;
    x_valid = 1'b0; cnt_clr = 1'b0; pattern_in = '0;
`ifdef SEQ_DET_MASK_EN
    mask_in = '1;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    en  = 1'b1;
    tick();                                  // IDLE -> FILL

    // overlapping hits of the reset pattern 1011
    send_bits(16'b1011011, 7, 0);
    chk("overlap_cnt", cnt_a, 8'd2);
    send_bits(16'b011011011, 9, 0);          // count reaches 5
    chk("pre_reset_cnt", cnt_a, 8'd5);
    chk("pre_reset_z", z_a, 1'b1);

    // asynchronous reset mid-stream, observed before the next edge
    rst = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    send_bits(16'b1011, 4, 0);               // reset pattern is back in force
    chk("post_reset_hit", z_a, 1'b1);

    // non-overlap: one hit in 1011011
    do_load(4'b1011, 1'b0, 1'b1);
    send_bits(16'b1011011, 7, 0);
    chk("nonoverlap_cnt", cnt_a, 8'd2);
    chk("nonoverlap_state", st_a, 2'd1);

    // valid gaps between bits
    do_load(4'b1011, 1'b1, 1'b0);
    send_bits(16'b1011, 4, 3);

    // saturation of the 2-bit counter, then clear coincident with a hit
    cnt_clr = 1'b1;
    do_load(4'b1111, 1'b1, 1'b1);
    send_bits(16'hFF, 8, 0);
    chk("sat_cnt_b", cnt_b, 2'd3);
    chk("sat_flag_b", sat_b, 1'b1);
    cnt_clr = 1'b1;
    x       = 1'b1;
    x_valid = 1'b1;
    tick();
    chk("clr_hit_z", z_b, 1'b1);
    chk("clr_hit_cnt", cnt_b, 2'd0);
    cnt_clr = 1'b0;

    // load mid-stream discards the coincident bit
    do_load(4'b1011, 1'b1, 1'b0);
    send_bits(16'b101, 3, 0);
    do_load(4'b0110, 1'b1, 1'b1);
    send_bits(16'b0110, 4, 0);
    chk("load_new_hit", z_a, 1'b1);
    send_bits(16'b1011, 4, 0);

    // en low: IDLE, and load only updates the pattern
    en = 1'b0;
    tick();
    do_load(4'b1001, 1'b1, 1'b1);
    chk("en_low_state", st_a, 2'd0);
    en = 1'b1;
    tick();
    send_bits(16'b1001, 4, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      en         = ($urandom_range(0, 19) != 0);
      load       = ($urandom_range(0, 24) == 0);
      pattern_in = W'($urandom_range(0, 15));
      overlap_in = 1'($urandom_range(0, 1));
      x_valid    = ($urandom_range(0, 3) != 0);
      x          = 1'($urandom_range(0, 1));
      cnt_clr    = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised serial sequence detector. Successor to the single-bit fixed-pattern Mealy/Moore detector (clk, rst, x -> z).
- Adds a runtime-loadable pattern of PATTERN_W bits, a qualified input strobe, overlap/non-overlap mode and a saturating match counter.
- Sits on a serial bit stream and flags pattern hits to downstream control logic.

Parameters:
PATTERN_W, 4, pattern length in bits (2..16)
CNT_W, 8, match counter width (>=1)
RST_PATTERN, 4'b1011, pattern value loaded at reset (PATTERN_W bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  detector enable; 0 forces IDLE
load  input  1  one-cycle strobe: latch pattern_in and overlap_in
pattern_in  input  PATTERN_W  new pattern, MSB = first bit received
overlap_in  input  1  1 = overlapping matches allowed
x  input  1  serial data bit
x_valid  input  1  x sampled only when 1
cnt_clr  input  1  synchronous clear of match counter
z  output  1  registered one-cycle match pulse
match_cnt  output  CNT_W  saturating count of matches
cnt_sat  output  1  1 while match_cnt is all ones
busy  output  1  1 in FILL or HUNT

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: z=0, match_cnt=0, cnt_sat=0, busy=0.
  - Internal state: shift register=0, fill count=0, state=IDLE, pattern=RST_PATTERN, overlap=1.
- Storage: window shift register SR[PATTERN_W-1:0]. On an accepted bit, SR <= {SR[PATTERN_W-2:0], x}.
- Fill counter: 0..PATTERN_W, saturates at PATTERN_W.
- States:
  - IDLE: en=0. SR and fill count held at 0; no bits accepted. en=1 -> FILL on next edge.
  - FILL: fill count < PATTERN_W. Accepted bits shift in and fill increments. When fill reaches PATTERN_W -> HUNT on the same edge.
  - HUNT: window full; every accepted bit is compared.
  - en=0 in any state -> IDLE next edge, clearing SR and fill.
- Accepted bit: x_valid=1 and state is FILL or HUNT. The bit that completes the fill (fill goes PATTERN_W-1 -> PATTERN_W) is compared in the same evaluation.
- Match evaluation: the post-shift window {SR[PATTERN_W-2:0], x} equals the stored pattern and the fill is complete.
  - On the sampling edge, z <= 1. z is high for exactly the following cycle, otherwise 0.
  - Latency: 1 clock from the edge sampling the final bit.
  - match_cnt increments, saturating at 2^CNT_W-1 (no wrap). cnt_sat = (match_cnt == all ones).
- Overlap mode:
  - overlap=1: after a match, stay in HUNT with the window intact.
  - overlap=0: after a match, fill <= 0 and state -> FILL, so the next match needs PATTERN_W fresh bits.
- x_valid=0: SR, fill and state hold; z <= 0.
- load=1 (any state with en=1):
  - pattern <= pattern_in, overlap <= overlap_in, SR <= 0, fill <= 0, state -> FILL, z <= 0.
  - A bit presented in the same cycle is discarded.
  - load with en=0 updates pattern and overlap only; state stays IDLE.
- cnt_clr=1: match_cnt <= 0. If a match occurs in the same cycle, clear wins (count 0) but z still pulses.
- busy = (state != IDLE), registered with state.
- Reset mid-stream: immediate return to reset values. A partial window is lost and the pattern reverts to RST_PATTERN.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input mask_in [PATTERN_W-1:0], latched on load alongside pattern_in.
  - Reset mask = all ones.
  - Match compares only bit positions where mask=1. A bit with mask=0 is don't-care.
  - A mask of all zeros matches as soon as the fill is complete, i.e. every accepted bit once in HUNT.
- Undefined: no mask port or register; exact compare on all PATTERN_W bits.

Test Plan:
- Reset: assert rst=0 mid-run with match_cnt=5 -> same cycle, z=0, match_cnt=0, busy=0; after release, pattern=1011.
- Overlap: en=1, overlap=1, stream x=1,0,1,1,0,1,1 (x_valid=1 every cycle) -> z pulses after bit 4 and bit 7; match_cnt=2.
- Non-overlap: load overlap_in=0, pattern 1011, same stream -> single z after bit 4; match_cnt=1; state FILL after the match.
- Valid gaps: stream 1,0,1,1 with x_valid=0 for 3 cycles between each bit -> one z pulse, exactly 1 cycle after the edge sampling the 4th bit; no z during gaps.
- Saturation/clear: CNT_W=2, 5 overlapping matches of pattern 1111 -> match_cnt=3, cnt_sat=1. cnt_clr coincident with a match -> match_cnt=0, z=1.
- Load mid-stream: after bits 1,0,1, load pattern 0110 with x=1 in the same cycle -> bit discarded; then 0,1,1,0 -> z after the 4th; the old pattern 1011 no longer matches.
